// File: rtl/gray_key_decoder_pkg.sv
// Shared Gray-code helpers and constants for the Gray-keyed decoder.
// The pipeline uses GRAY_NONE; bin2gray/gray2bin are for any logic that needs the mapping on up to 32 bits.
package gray_key_decoder_pkg;

  // Code 0 never names a table slot.
  localparam int GRAY_NONE = 0;

  function automatic logic [31:0] gray2bin(input logic [31:0] g);
    logic [31:0] b;
    b = g;
    for (int k = 30; k >= 0; k--) begin
      b[k] = b[k+1] ^ g[k];
    end
    return b;
  endfunction

  function automatic logic [31:0] bin2gray(input logic [31:0] b);
    return b ^ (b >> 1);
  endfunction

endpackage

// File: rtl/gray_key_decoder_gray2bin.sv
// Combinational Gray-to-binary converter: XOR prefix from the MSB down.
module gray_key_decoder_gray2bin #(
  parameter int DW = 2
) (
  input  logic [DW-1:0] gray,
  output logic [DW-1:0] bin
);

  always_comb begin
    bin = '0;
    bin[DW-1] = gray[DW-1];
    for (int k = DW - 2; k >= 0; k--) begin
      bin[k] = bin[k+1] ^ gray[k];
    end
  end

endmodule

// File: rtl/gray_key_decoder.sv
// Two-stage valid/ready pipeline: Gray index -> binary slot -> key lookup from a flat key table.
// Codes that name no slot (0 or above NR) pass through with hit=0 and a zero key.
module gray_key_decoder
  import gray_key_decoder_pkg::*;
#(
  parameter int NR = 2,
  parameter int KW = 1,
  parameter int DW = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [DW-1:0]    in_gray,
  input  logic [NR*KW-1:0] keys,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [DW-1:0]    out_idx,
  output logic [KW-1:0]    out_key,
  output logic             out_hit
);

  if ((2 ** DW) <= NR) begin : g_bad_width
    $error("gray_key_decoder: DW too small to index NR slots");
  end

  logic [DW-1:0] in_bin;
  logic          in_hit;
  logic          s1_valid;
  logic [DW-1:0] s1_idx;
  logic          s1_hit;
  logic          s1_adv;
  logic          s2_adv;
  logic [KW-1:0] key_sel;

  gray_key_decoder_gray2bin #(.DW(DW)) u_gray2bin (
    .gray (in_gray),
    .bin  (in_bin)
  );

  assign in_hit = (in_bin != DW'(GRAY_NONE)) && (32'(in_bin) <= 32'(NR));

  // A stage moves whenever the stage after it is empty or draining this cycle;
  // in_ready is therefore combinational from out_ready (no skid buffer).
  assign s2_adv   = !out_valid || out_ready;
  assign s1_adv   = !s1_valid || s2_adv;
  assign in_ready = s1_adv;

  always_comb begin
    key_sel = '0;
    for (int i = 1; i <= NR; i++) begin
      if (s1_hit && (32'(s1_idx) == 32'(i))) begin
        key_sel = keys[KW*(i-1) +: KW];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_idx   <= '0;
      s1_hit   <= 1'b0;
    end else if (s1_adv) begin
      s1_valid <= in_valid;
      if (in_valid) begin
        s1_idx <= in_bin;
        s1_hit <= in_hit;
      end
    end
  end

  // Keys are captured here, so later table edits never reach an item already in stage 2.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_idx   <= '0;
      out_key   <= '0;
      out_hit   <= 1'b0;
    end else if (s2_adv) begin
      out_valid <= s1_valid;
      if (s1_valid) begin
        out_idx <= s1_idx;
        out_hit <= s1_hit;
        out_key <= key_sel;
      end
    end
  end

endmodule

// File: tb/tb_gray_key_decoder.sv
// Directed bench for gray_key_decoder: scoreboard queue of expected {idx,key,hit} items.
module tb_gray_key_decoder;
  import gray_key_decoder_pkg::*;

  localparam int NR = 3;
  localparam int KW = 4;
  localparam int DW = 2;
  localparam int W  = DW + KW + 1;

  // clock / reset
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic             in_valid, in_ready, out_valid, out_ready, out_hit;
  logic [DW-1:0]    in_gray, out_idx;
  logic [NR*KW-1:0] keys;
  logic [KW-1:0]    out_key;

  logic             in_valid2, in_ready2, out_valid2, out_ready2, out_hit2;
  logic [DW-1:0]    in_gray2, out_idx2;
  logic [2*KW-1:0]  keys2;
  logic [KW-1:0]    out_key2;

  gray_key_decoder #(.NR(NR), .KW(KW), .DW(DW)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_gray(in_gray),
    .keys(keys), .out_valid(out_valid), .out_ready(out_ready), .out_idx(out_idx),
    .out_key(out_key), .out_hit(out_hit)
  );

  gray_key_decoder #(.NR(2), .KW(KW), .DW(DW)) dut2 (
    .clk(clk), .rst(rst), .in_valid(in_valid2), .in_ready(in_ready2), .in_gray(in_gray2),
    .keys(keys2), .out_valid(out_valid2), .out_ready(out_ready2), .out_idx(out_idx2),
    .out_key(out_key2), .out_hit(out_hit2)
  );

  int tests = 0;
  int fails = 0;
  int pops = 0;
  int run = 0;
  int run_max = 0;
  int p0;
  logic [W-1:0] exp_q[$];
  logic         stall_prev = 1'b0;
  logic [W-1:0] out_prev;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [W-1:0] model(input int idx);
    logic [KW-1:0] k;
    logic          hit;
    k = '0;
    hit = (idx >= 1) && (idx <= NR);
    if (hit) k = keys[KW*(idx-1) +: KW];
    return {DW'(idx), k, hit};
  endfunction

  // scoreboard: pop and compare every output handshake; also watch stall stability
  always @(negedge clk) begin
    if (rst) begin
      run = 0;
      stall_prev = 1'b0;
    end else begin
      if (stall_prev) check("stall_hold", 32'({out_idx, out_key, out_hit}), 32'(out_prev));
      if (out_valid && out_ready) begin
        pops++;
        run++;
        if (run > run_max) run_max = run;
        if (exp_q.size() == 0) begin
          tests++;
          fails++;
          $error("FAIL unexpected_out: observed item %0h expected none", {out_idx, out_key, out_hit});
        end else begin
          check("out_item", 32'({out_idx, out_key, out_hit}), 32'(exp_q.pop_front()));
        end
      end else begin
        run = 0;
      end
      stall_prev = out_valid && !out_ready;
      out_prev = {out_idx, out_key, out_hit};
    end
  end

  // driver tasks (called and returning at posedge+1)
  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send(input int idx);
    bit done;
    done = 1'b0;
    in_valid = 1'b1;
    in_gray = DW'(bin2gray(32'(idx)));
    for (int i = 0; i < 50 && !done; i++) begin
      @(negedge clk);
      if (in_ready) begin
        exp_q.push_back(model(idx));
        done = 1'b1;
      end
      @(posedge clk);
      #1;
    end
    if (!done) begin
      tests++;
      fails++;
      $error("FAIL send_timeout: observed in_ready 0 expected 1 within 50 cycles");
    end
  endtask

  task automatic drain();
    for (int i = 0; i < 50 && exp_q.size() != 0; i++) step(1);
    check("drain_empty", exp_q.size(), 0);
  endtask

  initial begin
    rst = 1'b1;
    in_valid = 1'b0;
    in_gray = '0;
    out_ready = 1'b1;
    keys = {4'hC, 4'hB, 4'hA};
    in_valid2 = 1'b0;
    in_gray2 = '0;
    out_ready2 = 1'b1;
    keys2 = {4'hB, 4'hA};

    // 1. reset state, single item, latency
    repeat (2) @(negedge clk);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_idx", out_idx, 0);
    check("rst_out_key", out_key, 0);
    check("rst_out_hit", out_hit, 0);
    @(negedge clk);
    rst = 1'b0;
    step(1);
    check("rel_in_ready", in_ready, 1);
    check("rel_out_valid", out_valid, 0);
    send(2);
    in_valid = 1'b0;
    check("lat_cycle1", out_valid, 0);
    step(1);
    check("lat_cycle2", out_valid, 1);
    check("t1_idx", out_idx, 2);
    check("t1_key", out_key, 4'hB);
    check("t1_hit", out_hit, 1);
    drain();

    // 2. back-to-back full throughput
    step(2);
    run_max = 0;
    send(1);
    send(2);
    send(3);
    in_valid = 1'b0;
    drain();
    step(2);
    check("t2_consecutive", run_max, 3);

    // 3. code 0, and out-of-range on an NR=2 build
    send(0);
    in_valid = 1'b0;
    drain();
    in_valid2 = 1'b1;
    in_gray2 = 2'b10;
    check("t3_ready2", in_ready2, 1);
    step(1);
    in_valid2 = 1'b0;
    step(1);
    check("t3_valid2", out_valid2, 1);
    check("t3_idx2", out_idx2, 3);
    check("t3_hit2", out_hit2, 0);
    check("t3_key2", out_key2, 0);

    // 4. output stall for 5 cycles while streaming
    step(2);
    p0 = pops;
    out_ready = 1'b0;
    send(1);
    send(2);
    in_valid = 1'b1;
    in_gray = DW'(bin2gray(32'd3));
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("t4_in_ready", in_ready, 0);
      check("t4_out_valid", out_valid, 1);
      check("t4_out_idx", out_idx, 1);
      check("t4_out_key", out_key, 4'hA);
      check("t4_out_hit", out_hit, 1);
      @(posedge clk);
      #1;
    end
    out_ready = 1'b1;
    send(3);
    in_valid = 1'b0;
    drain();
    step(2);
    check("t4_count", pops - p0, 3);

    // 5. key table edit after the item has entered stage 2
    send(2);
    in_valid = 1'b0;
    step(1);
    keys[7:4] = 4'hE;
    check("t5_key_held", out_key, 4'hB);
    drain();
    send(2);
    in_valid = 1'b0;
    drain();

    // 6. reset with both stages full and output stalled
    step(2);
    out_ready = 1'b0;
    send(1);
    send(3);
    in_valid = 1'b0;
    check("t6_full_valid", out_valid, 1);
    check("t6_full_ready", in_ready, 0);
    rst = 1'b1;
    #1;
    check("t6_async_valid", out_valid, 0);
    check("t6_async_idx", out_idx, 0);
    exp_q.delete();
    step(2);
    rst = 1'b0;
    out_ready = 1'b1;
    p0 = pops;
    step(6);
    check("t6_no_stale", pops - p0, 0);
    check("t6_idle_valid", out_valid, 0);

    check("final_queue", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
